phys_reg_free_list: RTL
=======================

Name: phys_reg_free_list

Overview:
- Circular FIFO of free physical-register tags that feeds the rename stage.
- Rename takes one tag per cycle for each instruction whose rd != x0; retire returns one tag per cycle (the stale mapping being released).
- Physical tags p0..p31 hold the architectural state at reset; p32..p63 start free.
- Exposes occupancy, a rename stall, and an error flag for illegal frees.

Parameters:
- NUM_PREGS, 64, total physical registers; tag width is log2(NUM_PREGS) = 6.
- NUM_AREGS, 32, architectural registers; these are mapped at reset.
- DEPTH, NUM_PREGS-NUM_AREGS (32), FIFO capacity.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- alloc_req  input  1  rename requests one tag this cycle.
- alloc_valid  output  1  combinational; = alloc_req && (count != 0). The tag is consumed at the next posedge.
- alloc_preg  output  6  combinational; tag at the head. Driven whenever count != 0, otherwise 0.
- stall  output  1  combinational; = alloc_req && (count == 0).
- free_valid  input  1  retire returns a tag this cycle.
- free_preg  input  6  tag being returned.
- count  output  7  registered; number of free tags, 0..DEPTH.
- free_err  output  1  registered one-cycle pulse when a free is rejected.

Behaviour:
- Storage is mem[DEPTH] x 6 bits, with 5-bit head and tail pointers that wrap modulo DEPTH and a 7-bit count.
- Reset (rst=1 at posedge):
  - mem[i] = NUM_AREGS+i for i = 0..31.
  - head = 0, tail = 0, count = 32, free_err = 0.
  - During reset, alloc_valid = 0 and stall = 0 regardless of alloc_req.
  - Reset mid-operation discards all in-flight state and restores exactly the above.
- Allocation: a do_alloc = alloc_valid. At the posedge, head <= head+1 (mod DEPTH).
- Free acceptance:
  - do_free = free_valid && free_preg != 0 && (count < DEPTH || do_alloc).
  - On do_free: mem[tail] <= free_preg, tail <= tail+1 (mod DEPTH).
- Rejected frees (no pointer or memory change):
  - free_preg == 0: p0 is hardwired zero and never recycled. Ignored silently, free_err stays 0.
  - count == DEPTH && !do_alloc: overflow. free_err <= 1 for exactly one cycle.
- free_err <= 0 on every cycle without an overflow reject.
- count update: count <= count + do_free - do_alloc. Simultaneous alloc and free leave count unchanged; both pointers advance.
- Empty with a simultaneous free: no bypass.
  - alloc_valid = 0 and stall = 1 this cycle.
  - The freed tag is written, count becomes 1, and it is allocatable next cycle.
- Full with a simultaneous alloc and free: both accepted, count stays at DEPTH, free_err = 0.
- Tag order is strict FIFO. No duplicate detection: a double-free is the caller's error and is not checked.
- Latency: allocation tag is available in the same cycle (combinational read of mem[head]); a freed tag becomes visible at the earliest one cycle later.

Test Plan:
- Reset then idle:
  - count=32, alloc_preg=32, free_err=0.
  - Assert alloc_req 3 cycles -> alloc_preg sequence 32, 33, 34; count=29.
- Drain:
  - alloc_req held 32 cycles -> tags 32..63 in order; count=0.
  - 33rd cycle: stall=1, alloc_valid=0, alloc_preg=0.
- Empty + free same cycle:
  - count=0, alloc_req=1, free_valid=1, free_preg=40 -> stall=1 this cycle.
  - Next cycle alloc_preg=40, alloc_valid=1, count=1.
- Overflow:
  - From reset (count=32), free_valid=1, free_preg=5, no alloc -> count stays 32, free_err=1 for one cycle, then 0.
  - Same stimulus with alloc_req=1 -> free accepted, count=32, free_err=0, tag 5 reappears after 31 further allocations.
- p0 and wrap:
  - free_preg=0 -> ignored, count unchanged, free_err=0.
  - Cycle 40 alloc/free pairs (free tags 10..49) -> head and tail wrap past 31; count constant at 32; alloc order is 32..63 then 10..17.
- Reset mid-operation: after 5 allocs and 2 frees, assert rst one cycle -> count=32, alloc_preg=32, free_err=0.

Source files
------------

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical-register tags feeding rename.
// p0..p(NUM_AREGS-1) start mapped; the remaining tags start free, in order.
module phys_reg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int DEPTH     = NUM_PREGS - NUM_AREGS,
  parameter int TAG_W     = $clog2(NUM_PREGS),
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(DEPTH) + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_valid,
  output logic [TAG_W-1:0] alloc_preg,
  output logic             stall,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_preg,
  output logic [CNT_W-1:0] count,
  output logic             free_err
);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             free_err_q, free_err_d;

  logic             empty;
  logic             full;
  logic             do_alloc;
  logic             do_free;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign alloc_valid = !rst && alloc_req && !empty;
  assign stall       = !rst && alloc_req && empty;
  assign alloc_preg  = empty ? '0 : mem_q[head_q];
  assign do_alloc    = alloc_valid;
  // A full list can still take a free when the same cycle frees a slot.
  assign do_free     = free_valid && (free_preg != '0) && (!full || do_alloc);
  assign count       = count_q;
  assign free_err    = free_err_q;

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q + CNT_W'(do_free) - CNT_W'(do_alloc);
    free_err_d = free_valid && (free_preg != '0) && full && !do_alloc;
    if (do_alloc) begin
      head_d = ptr_inc(head_q);
    end
    if (do_free) begin
      mem_d[tail_q] = free_preg;
      tail_d        = ptr_inc(tail_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= TAG_W'(NUM_AREGS + i);
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= CNT_W'(DEPTH);
      free_err_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      free_err_q <= free_err_d;
    end
  end

endmodule
